// File: rtl/norm_32_seq_pkg.sv
// norm_pkg: shared constants for the iterative 32-bit normalizer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Holds the FSM state encoding, the stage count and the per-stage
// shift-size table walked by the step index.
package norm_pkg;

  localparam int WIDTH = 32;
  localparam int STEPS = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Binary-search stage sizes, indexed by the step counter.
  localparam logic [4:0] STAGE_K [STEPS] = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

endpackage

// File: rtl/norm_32_seq_if.sv
// norm_32_seq_if: request/result bundle of the normalizer.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while busy is low.
// master drives start/x/sgn, slave returns busy/done/norm/cnt/zero.
interface norm_32_seq_if;

  logic        start;
  logic [31:0] x;
  logic        sgn;    // 0: leading zeros, 1: redundant sign bits
  logic        busy;
  logic        done;
  logic [31:0] norm;
  logic [5:0]  cnt;
  logic        zero;

  modport master (
    output start, x, sgn,
    input  busy, done, norm, cnt, zero
  );

  modport slave (
    input  start, x, sgn,
    output busy, done, norm, cnt, zero
  );

endinterface

// File: rtl/norm_32_seq_step.sv
// mux2_32 / norm_step: one combinational binary-search stage of the normalizer.
// Latency: combinational.
// Backpressure: none.
// Ports (norm_step): w in, k stage size, sgn mode -> w_out (shifted or held), hit.
module mux2_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sel,
  output logic [31:0] y
);

  assign y = sel ? b : a;

endmodule

module norm_step
  import norm_pkg::*;
(
  input  logic [WIDTH-1:0] w,
  input  logic [4:0]       k,
  input  logic             sgn,
  output logic [WIDTH-1:0] w_out,
  output logic             hit
);

  logic [5:0]       k1;
  logic [WIDTH-1:0] mask_u;
  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] top_s;
  logic [WIDTH-1:0] shifted;

  // Unsigned looks at the top k bits; signed needs the top k+1 bits equal
  // so that the sign survives the shift.
  assign k1      = {1'b0, k} + 6'd1;
  assign mask_u  = ~({WIDTH{1'b1}} >> k);
  assign mask_s  = ~({WIDTH{1'b1}} >> k1);
  assign top_s   = w & mask_s;
  assign hit     = sgn ? ((top_s == '0) || (top_s == mask_s))
                       : ((w & mask_u) == '0);
  assign shifted = w << k;

  mux2_32 u_mux (
    .a   (w),
    .b   (shifted),
    .sel (hit),
    .y   (w_out)
  );

endmodule

// File: rtl/norm_32_seq.sv
// norm_32_seq: iterative CLZ/CLS normalizer, one search stage (16,8,4,2,1) per clock.
// Latency: accept edge to done = 6 cycles; throughput 1 op / 6 cycles when chained.
// Backpressure: start ignored while busy (no queuing); accepted in IDLE and DONE.
// Ports: clk, rst (async, high); bus.slave = start/x/sgn in, busy/done/norm/cnt/zero out.
module norm_32_seq
  import norm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  norm_32_seq_if.slave  bus
);

  state_t           state, state_nxt;
  logic [2:0]       step;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] norm_q;
  logic [5:0]       cnt_q;
  logic             zero_q;
  logic             mode_q;
  logic             hit;
  logic             accept;
  logic             last;
  logic [4:0]       k;

  // step only ranges 0..STEPS-1 while running; the guard keeps k sane otherwise.
  assign k = (step < 3'(STEPS)) ? STAGE_K[step] : 5'd1;

  norm_step u_step (
    .w     (w),
    .k     (k),
    .sgn   (mode_q),
    .w_out (w_step),
    .hit   (hit)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (step == 3'(STEPS - 1)) begin
          last      = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // A start here chains straight into the next operation.
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w      <= '0;
      step   <= '0;
      norm_q <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
      mode_q <= 1'b0;
    end else if (accept) begin
      w      <= bus.x;
      step   <= '0;
      cnt_q  <= '0;
      zero_q <= (bus.x == '0);
      mode_q <= bus.sgn;
    end else if (state == S_RUN) begin
      w    <= w_step;
      step <= last ? 3'd0 : step + 3'd1;
      if (last) norm_q <= w_step;
      // Unsigned zero only accumulates 31 through the stages; report a full 32.
      if (last && !mode_q && zero_q) cnt_q <= 6'd32;
      else if (hit)                  cnt_q <= cnt_q + {1'b0, k};
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.norm = norm_q;
  assign bus.cnt  = cnt_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_norm_32_seq.sv
// tb_norm_32_seq: scoreboard bench for norm_32_seq.
// Latency: checks done arrives exactly 6 cycles after each accepted start.
// Backpressure: issues starts while busy and expects them to be dropped.
module tb_norm_32_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  norm_32_seq_if bus ();

  norm_32_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] norm;
    logic [5:0]  cnt;
    logic        zero;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Independent bit-by-bit reference for CLZ / CLS.
  function automatic void model(input logic [31:0] xv, input logic s,
                                output logic [31:0] n, output logic [5:0] c);
    int k;
    k = 0;
    if (!s) begin
      if (xv == 32'd0) k = 32;
      else while (xv[31-k] == 1'b0) k++;
    end else begin
      while (k < 31 && xv[30-k] == xv[31]) k++;
    end
    c = 6'(k);
    n = xv << k;
  endfunction

  // Monitor: every done must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: done seen at cycle %0d with nothing outstanding", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("norm", bus.norm, mon_e.norm);
        chk("cnt", 32'(bus.cnt), 32'(mon_e.cnt));
        chk("zero", 32'(bus.zero), 32'(mon_e.zero));
        chk("latency", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  // Called at a negedge; presents start for one cycle, returns at the next negedge.
  task automatic drive(input logic [31:0] xv, input logic s, input bit push,
                       input logic [31:0] en, input logic [5:0] ec, input logic ez);
    bus.start = 1'b1;
    bus.x     = xv;
    bus.sgn   = s;
    if (push) q.push_back('{en, ec, ez, cyc + 6});
    @(negedge clk);
    // Scramble operands after the accept; the result must not care.
    bus.start = 1'b0;
    bus.x     = $urandom;
    bus.sgn   = ~s;
  endtask

  typedef struct {
    logic [31:0] x;
    logic        s;
    logic [31:0] n;
    logic [5:0]  c;
    logic        z;
  } vec_t;

  vec_t vecs[10] = '{
    '{32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1},
    '{32'h0000_0000, 1'b1, 32'h0000_0000, 6'd31, 1'b1},
    '{32'hFFFF_FFF0, 1'b1, 32'h8000_0000, 6'd27, 1'b0},
    '{32'h0001_2345, 1'b1, 32'h48D1_4000, 6'd14, 1'b0},
    '{32'h0001_2345, 1'b0, 32'h91A2_8000, 6'd15, 1'b0},
    '{32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 6'd31, 1'b0},
    '{32'h8000_0000, 1'b0, 32'h8000_0000, 6'd0,  1'b0},
    '{32'h4000_0000, 1'b1, 32'h4000_0000, 6'd0,  1'b0},
    '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 6'd0,  1'b0},
    '{32'h0000_8000, 1'b0, 32'h8000_0000, 6'd16, 1'b0}
  };

  initial begin
    logic [31:0] rx;
    logic        rs;
    logic [31:0] rn;
    logic [5:0]  rc;

    bus.start = 1'b0;
    bus.x     = '0;
    bus.sgn   = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_norm", bus.norm, 32'd0);
    chk("rst_cnt", 32'(bus.cnt), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // First op: busy for cycles 1..5, done at 6.
    drive(32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 6'd31, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      chk("busy_run", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    chk("busy_at_done", 32'(bus.busy), 32'd0);

    // Directed vectors, each started in the previous op's DONE cycle.
    foreach (vecs[i]) begin
      drive(vecs[i].x, vecs[i].s, 1'b1, vecs[i].n, vecs[i].c, vecs[i].z);
      repeat (5) @(negedge clk);
    end

    // Starts at cycles 2 and 4 dropped; start in DONE cycle accepted.
    @(negedge clk);
    drive(32'h0000_0300, 1'b0, 1'b1, 32'hC000_0000, 6'd22, 1'b0);
    @(negedge clk);
    chk("busy_c2", 32'(bus.busy), 32'd1);
    drive(32'h0000_FFFF, 1'b0, 1'b0, 32'd0, 6'd0, 1'b0);
    @(negedge clk);
    chk("busy_c4", 32'(bus.busy), 32'd1);
    drive(32'h0000_0001, 1'b1, 1'b0, 32'd0, 6'd0, 1'b0);
    @(negedge clk);
    drive(32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 6'd0, 1'b0);
    repeat (6) @(negedge clk);

    // Asynchronous reset in the middle of a run.
    drive(32'h0001_2345, 1'b0, 1'b0, 32'd0, 6'd0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_norm", bus.norm, 32'd0);
    chk("arst_cnt", 32'(bus.cnt), 32'd0);
    chk("arst_zero", 32'(bus.zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    drive(32'h0001_2345, 1'b0, 1'b1, 32'h91A2_8000, 6'd15, 1'b0);
    repeat (5) @(negedge clk);

    // Randomised sweep against the bit-serial model, both modes.
    for (int i = 0; i < 300; i++) begin
      rx = $urandom >> $urandom_range(0, 31);
      rs = 1'($urandom_range(0, 1));
      if (rs && $urandom_range(0, 1) == 1) rx = ~rx;
      model(rx, rs, rn, rc);
      drive(rx, rs, 1'b1, rn, rc, rx == 32'd0);
      repeat (5) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
